// File: rtl/aeq_pkg.sv
// rtl/aeq_pkg.sv - shared types and constants for the AEQ calibration sequencer
package aeq_pkg;

  // Sequencer states
  typedef enum logic [2:0] {
    IDLE,
    SCAN,
    ISSUE,
    WAIT_RISE,
    WAIT_FALL,
    FINISH
  } aeq_state_e;

  // Operation encoding captured from op_shutdown at start
  localparam logic AEQ_OP_CAL      = 1'b0;
  localparam logic AEQ_OP_SHUTDOWN = 1'b1;

  // Default configuration
  localparam int AEQ_DEFAULT_CHANNELS    = 5;
  localparam int AEQ_DEFAULT_ADDR_WIDTH  = 3;
  localparam int AEQ_DEFAULT_TIMEOUT     = 1024;
  localparam int AEQ_DEFAULT_RISE_WINDOW = 4;

endpackage

// File: rtl/aeq_busy_watchdog.sv
// rtl/aeq_busy_watchdog.sv - saturating per-channel watchdog for engine busy handshake
module aeq_busy_watchdog
  import aeq_pkg::*;
#(
  parameter int timeout_cycles   = AEQ_DEFAULT_TIMEOUT,
  parameter int busy_rise_window = AEQ_DEFAULT_RISE_WINDOW
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic rise_expired,
  output logic fall_expired
);

  localparam int CW = $clog2(timeout_cycles + 1);

  logic [CW-1:0] cnt_q, cnt_d;

  // Count holds cycles elapsed since the command pulse: clear loads 1 so the
  // first wait cycle already reads 1; saturate at timeout_cycles, never wrap.
  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = CW'(1);
    end else if (enable && (cnt_q != CW'(timeout_cycles))) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Counter register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign rise_expired = (cnt_q > CW'(busy_rise_window));
  assign fall_expired = (cnt_q >= CW'(timeout_cycles));

endmodule

// File: rtl/aeq_cal_sequencer.sv
// rtl/aeq_cal_sequencer.sv - per-channel AEQ calibrate/shutdown sequencer (optional retry: AEQ_CAL_SEQ_RETRY_EN)
module aeq_cal_sequencer
  import aeq_pkg::*;
#(
  parameter int number_of_channels    = AEQ_DEFAULT_CHANNELS,
  parameter int channel_address_width = AEQ_DEFAULT_ADDR_WIDTH,
  parameter int timeout_cycles        = AEQ_DEFAULT_TIMEOUT,
  parameter int busy_rise_window      = AEQ_DEFAULT_RISE_WINDOW
) (
  input  logic                             reconfig_clk,
  input  logic                             aclr_n,
  input  logic                             start,
  input  logic                             op_shutdown,
  input  logic [number_of_channels-1:0]    channel_mask,
  input  logic                             abort,
  input  logic                             aeq_busy,
  output logic                             calibrate,
  output logic                             shutdown,
  output logic                             all_channels,
  output logic [channel_address_width-1:0] logical_channel_address,
  output logic                             seq_busy,
  output logic                             seq_done,
  output logic [number_of_channels-1:0]    chan_ok,
  output logic [number_of_channels-1:0]    chan_timeout
);

  localparam logic [channel_address_width-1:0] LAST_IDX =
    channel_address_width'(number_of_channels - 1);

  aeq_state_e                       state_q, state_d;
  logic [channel_address_width-1:0] idx_q, idx_d;
  logic [number_of_channels-1:0]    mask_q, mask_d;
  logic [number_of_channels-1:0]    ok_q, ok_d;
  logic [number_of_channels-1:0]    to_q, to_d;
  logic                             op_q, op_d;
`ifdef AEQ_CAL_SEQ_RETRY_EN
  logic                             retry_q, retry_d;
`endif

  logic wd_clear, wd_enable, rise_expired, fall_expired;
  logic chan_pass, chan_fail, advance;

  aeq_busy_watchdog #(
    .timeout_cycles   (timeout_cycles),
    .busy_rise_window (busy_rise_window)
  ) u_watchdog (
    .clk          (reconfig_clk),
    .rst_n        (aclr_n),
    .clear        (wd_clear),
    .enable       (wd_enable),
    .rise_expired (rise_expired),
    .fall_expired (fall_expired)
  );

  // Next-state logic: channel walk, handshake supervision and status capture
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    mask_d    = mask_q;
    op_d      = op_q;
    ok_d      = ok_q;
    to_d      = to_q;
`ifdef AEQ_CAL_SEQ_RETRY_EN
    retry_d   = retry_q;
`endif
    wd_clear  = 1'b0;
    wd_enable = 1'b0;
    chan_pass = 1'b0;
    chan_fail = 1'b0;
    advance   = 1'b0;

    if (abort && (state_q != IDLE)) begin
      // Abort wins over everything; status bits are left untouched
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            mask_d  = channel_mask;
            op_d    = op_shutdown;
            ok_d    = '0;
            to_d    = '0;
            idx_d   = '0;
`ifdef AEQ_CAL_SEQ_RETRY_EN
            retry_d = 1'b0;
`endif
            state_d = SCAN;
          end
        end
        SCAN: begin
          if (mask_q[idx_q]) begin
            state_d = ISSUE;
          end else if (idx_q == LAST_IDX) begin
            state_d = FINISH;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
        ISSUE: begin
          wd_clear = 1'b1;
          state_d  = WAIT_RISE;
        end
        WAIT_RISE: begin
          wd_enable = 1'b1;
          if (aeq_busy) begin
            state_d = WAIT_FALL;
          end else if (rise_expired) begin
            chan_fail = 1'b1;
          end
        end
        WAIT_FALL: begin
          wd_enable = 1'b1;
          if (!aeq_busy) begin
            chan_pass = 1'b1;
          end else if (fall_expired) begin
            chan_fail = 1'b1;
          end
        end
        FINISH: begin
          state_d = IDLE;
        end
        default: begin
          state_d = IDLE;
        end
      endcase

      if (chan_fail) begin
`ifdef AEQ_CAL_SEQ_RETRY_EN
        // First timeout re-issues the command once on the same channel
        if (!retry_q) begin
          retry_d = 1'b1;
          state_d = ISSUE;
        end else begin
          to_d[idx_q] = 1'b1;
          advance     = 1'b1;
        end
`else
        to_d[idx_q] = 1'b1;
        advance     = 1'b1;
`endif
      end

      if (chan_pass) begin
        ok_d[idx_q] = 1'b1;
        advance     = 1'b1;
      end

      if (advance) begin
`ifdef AEQ_CAL_SEQ_RETRY_EN
        retry_d = 1'b0;
`endif
        if (idx_q == LAST_IDX) begin
          state_d = FINISH;
        end else begin
          idx_d   = idx_q + 1'b1;
          state_d = SCAN;
        end
      end
    end
  end

  // State and captured-context registers
  always_ff @(posedge reconfig_clk or negedge aclr_n) begin
    if (!aclr_n) begin
      state_q <= IDLE;
      idx_q   <= '0;
      mask_q  <= '0;
      ok_q    <= '0;
      to_q    <= '0;
      op_q    <= AEQ_OP_CAL;
`ifdef AEQ_CAL_SEQ_RETRY_EN
      retry_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      mask_q  <= mask_d;
      ok_q    <= ok_d;
      to_q    <= to_d;
      op_q    <= op_d;
`ifdef AEQ_CAL_SEQ_RETRY_EN
      retry_q <= retry_d;
`endif
    end
  end

  // Command pulses decode straight from state so reset kills them at once
  // and a same-cycle abort can still suppress them.
  assign calibrate = (state_q == ISSUE) && !abort && (op_q == AEQ_OP_CAL);
  assign shutdown  = (state_q == ISSUE) && !abort && (op_q == AEQ_OP_SHUTDOWN);

  assign all_channels            = 1'b0;
  assign logical_channel_address = idx_q;
  assign seq_busy                = (state_q != IDLE);
  assign seq_done                = (state_q == FINISH) || ((state_q != IDLE) && abort);
  assign chan_ok                 = ok_q;
  assign chan_timeout            = to_q;

endmodule

// File: tb/tb_aeq_cal_sequencer.sv
// tb/tb_aeq_cal_sequencer.sv - directed table-driven bench for aeq_cal_sequencer
module tb_aeq_cal_sequencer;
  import aeq_pkg::*;

  localparam int N  = 5;
  localparam int AW = 3;
`ifdef AEQ_CAL_SEQ_RETRY_EN
  localparam int RETRY = 1;
`else
  localparam int RETRY = 0;
`endif
  localparam int FOREVER = 1000000;

  logic          clk = 1'b0;
  logic          aclr_n = 1'b0;
  logic          start = 1'b0;
  logic          op_shutdown = 1'b0;
  logic [N-1:0]  channel_mask = '0;
  logic          abort = 1'b0;
  logic          aeq_busy = 1'b0;
  logic          calibrate, shutdown, all_channels, seq_busy, seq_done;
  logic [AW-1:0] addr;
  logic [N-1:0]  chan_ok, chan_timeout;

  aeq_cal_sequencer #(
    .number_of_channels    (N),
    .channel_address_width (AW),
    .timeout_cycles        (1024),
    .busy_rise_window      (4)
  ) dut (
    .reconfig_clk            (clk),
    .aclr_n                  (aclr_n),
    .start                   (start),
    .op_shutdown             (op_shutdown),
    .channel_mask            (channel_mask),
    .abort                   (abort),
    .aeq_busy                (aeq_busy),
    .calibrate               (calibrate),
    .shutdown                (shutdown),
    .all_channels            (all_channels),
    .logical_channel_address (addr),
    .seq_busy                (seq_busy),
    .seq_done                (seq_done),
    .chan_ok                 (chan_ok),
    .chan_timeout            (chan_timeout)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Engine model and monitor, both on the falling edge
  int          eng_len [8];
  int          base_pulse = 0;
  int          npulse = 0, ndone = 0, nboth = 0, nallch = 0;
  int          rem = 0;
  int          p_addr [64];
  logic        p_op   [64];
  int          p_cyc  [64];
  int          done_cyc = 0, to_cyc = 0;
  logic [N-1:0] prev_to = '0;

  always @(negedge clk) begin
    if (!aclr_n) rem = 0;
    aeq_busy = (rem > 0);
    if (rem > 0) rem = rem - 1;
    if (calibrate && shutdown) nboth = nboth + 1;
    if (all_channels) nallch = nallch + 1;
    if (calibrate || shutdown) begin
      p_addr[npulse % 64] = int'(addr);
      p_op[npulse % 64]   = shutdown;
      p_cyc[npulse % 64]  = cyc;
      rem = eng_len[((npulse - base_pulse) < 8) ? (npulse - base_pulse) : 7];
      npulse = npulse + 1;
    end
    if (seq_done) begin
      ndone = ndone + 1;
      done_cyc = cyc;
    end
    if ((chan_timeout != '0) && (prev_to == '0)) to_cyc = cyc;
    prev_to = chan_timeout;
  end

  int errors = 0, checks = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks = checks + 1;
    if (act !== exp) begin
      errors = errors + 1;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  int base_done, base_both, s_cyc;

  task automatic snap();
    base_pulse = npulse;
    base_done  = ndone;
    base_both  = nboth;
  endtask

  task automatic do_start(input logic [N-1:0] m, input logic op);
    channel_mask = m;
    op_shutdown  = op;
    start        = 1'b1;
    s_cyc        = cyc;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done(input string name);
    int n;
    n = 0;
    while ((ndone == base_done) && (n < 6000)) begin
      tick();
      n++;
    end
    chk({name, "_done_seen"}, int'(ndone != base_done), 1);
    repeat (3) tick();
  endtask

  function automatic logic [N-1:0] addr_set();
    logic [N-1:0] s;
    s = '0;
    for (int i = base_pulse; i < npulse; i++) s[p_addr[i % 64]] = 1'b1;
    return s;
  endfunction

  function automatic int wrong_op(input logic op);
    int c;
    c = 0;
    for (int i = base_pulse; i < npulse; i++) if (p_op[i % 64] != op) c++;
    return c;
  endfunction

  typedef struct {
    string        name;
    logic [N-1:0] mask;
    logic         op;
    int           len;
    int           exp_np;
    logic [N-1:0] exp_addr;
    logic [N-1:0] exp_ok;
    logic [N-1:0] exp_to;
    int           exp_lat;
  } vec_t;

  vec_t vt [6];

  initial begin
    vt[0] = '{"cal_10101",  5'b10101, AEQ_OP_CAL,      256, 3,         5'b10101, 5'b10101, 5'b00000, 0};
    vt[1] = '{"shut_00010", 5'b00010, AEQ_OP_SHUTDOWN, 15,  1,         5'b00010, 5'b00010, 5'b00000, 0};
    // never busy: 5 WAIT_RISE cycles after the pulse, flag visible on the 6th
    vt[2] = '{"nobusy",     5'b00001, AEQ_OP_CAL,      0,   1 + RETRY, 5'b00001, 5'b00000, 5'b00001, 6};
    vt[3] = '{"zero_mask",  5'b00000, AEQ_OP_CAL,      5,   0,         5'b00000, 5'b00000, 5'b00000, 0};
    vt[4] = '{"shut_all",   5'b11111, AEQ_OP_SHUTDOWN, 1,   5,         5'b11111, 5'b11111, 5'b00000, 0};
    vt[5] = '{"last_only",  5'b10000, AEQ_OP_CAL,      2,   1,         5'b10000, 5'b10000, 5'b00000, 0};
    for (int i = 0; i < 8; i++) eng_len[i] = 0;

    // Reset state
    repeat (3) tick();
    chk("rst_seq_busy", int'(seq_busy), 0);
    chk("rst_cmd", int'(calibrate | shutdown), 0);
    chk("rst_done", int'(seq_done), 0);
    chk("rst_addr", int'(addr), 0);
    chk("rst_ok", int'(chan_ok), 0);
    chk("rst_to", int'(chan_timeout), 0);
    aclr_n = 1'b1;
    tick();

    // Table-driven sequences
    for (int v = 0; v < 6; v++) begin
      for (int i = 0; i < 8; i++) eng_len[i] = vt[v].len;
      snap();
      do_start(vt[v].mask, vt[v].op);
      wait_done(vt[v].name);
      chk({vt[v].name, "_npulse"}, npulse - base_pulse, vt[v].exp_np);
      chk({vt[v].name, "_addrs"}, int'(addr_set()), int'(vt[v].exp_addr));
      chk({vt[v].name, "_wrong_op"}, wrong_op(vt[v].op), 0);
      chk({vt[v].name, "_ok"}, int'(chan_ok), int'(vt[v].exp_ok));
      chk({vt[v].name, "_to"}, int'(chan_timeout), int'(vt[v].exp_to));
      chk({vt[v].name, "_ndone"}, ndone - base_done, 1);
      chk({vt[v].name, "_both"}, nboth - base_both, 0);
      chk({vt[v].name, "_idle"}, int'(seq_busy), 0);
      if (vt[v].exp_lat > 0)
        chk({vt[v].name, "_lat"}, to_cyc - p_cyc[(npulse - 1) % 64], vt[v].exp_lat);
    end

    // Zero mask: FINISH after five SCAN cycles; a second start is ignored
    for (int i = 0; i < 8; i++) eng_len[i] = 5;
    snap();
    do_start(5'b00000, AEQ_OP_CAL);
    chk("zm_busy", int'(seq_busy), 1);
    channel_mask = 5'b11111;
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_done("zm");
    chk("zm_done_cyc", done_cyc - s_cyc, 6);
    repeat (20) tick();
    chk("zm_npulse", npulse - base_pulse, 0);
    chk("zm_ndone", ndone - base_done, 1);

    // Abort 10 cycles into channel 2
    for (int i = 0; i < 8; i++) eng_len[i] = 256;
    snap();
    do_start(5'b11111, AEQ_OP_CAL);
    for (int n = 0; (n < 3000) && ((npulse - base_pulse) < 3); n++) tick();
    chk("ab_reach_ch2", npulse - base_pulse, 3);
    repeat (10) tick();
    abort = 1'b1;
    s_cyc = cyc;
    tick();
    abort = 1'b0;
    repeat (300) tick();
    chk("ab_npulse", npulse - base_pulse, 3);
    chk("ab_addrs", int'(addr_set()), 5'b00111);
    chk("ab_ok", int'(chan_ok), 5'b00011);
    chk("ab_to", int'(chan_timeout), 0);
    chk("ab_ndone", ndone - base_done, 1);
    chk("ab_done_cyc", done_cyc - s_cyc, 0);
    chk("ab_idle", int'(seq_busy), 0);

    // Abort landing on the ISSUE cycle suppresses the command
    for (int i = 0; i < 8; i++) eng_len[i] = 5;
    snap();
    do_start(5'b00001, AEQ_OP_CAL);
    tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    repeat (10) tick();
    chk("abi_npulse", npulse - base_pulse, 0);
    chk("abi_ndone", ndone - base_done, 1);
    chk("abi_idle", int'(seq_busy), 0);

    // Busy stuck high on channel 0: timeout 1024 cycles after the pulse, then channel 1
    eng_len[0] = FOREVER;
    eng_len[1] = (RETRY != 0) ? FOREVER : 3;
    for (int i = 2; i < 8; i++) eng_len[i] = 3;
    snap();
    do_start(5'b00011, AEQ_OP_CAL);
    wait_done("stuck");
    chk("stuck_to", int'(chan_timeout), 5'b00001);
    chk("stuck_ok", int'(chan_ok), 5'b00010);
    chk("stuck_npulse", npulse - base_pulse, 2 + RETRY);
    chk("stuck_last_addr", p_addr[(npulse - 1) % 64], 1);
    chk("stuck_lat", to_cyc - p_cyc[(base_pulse + RETRY) % 64], 1025);

    // Asynchronous reset mid-sequence
    for (int i = 0; i < 8; i++) eng_len[i] = 256;
    snap();
    do_start(5'b11111, AEQ_OP_CAL);
    for (int n = 0; (n < 100) && ((npulse - base_pulse) < 1); n++) tick();
    repeat (3) tick();
    chk("ar_busy_before", int'(seq_busy), 1);
    #2;
    aclr_n = 1'b0;
    #1;
    chk("ar_busy", int'(seq_busy), 0);
    chk("ar_cmd", int'(calibrate | shutdown), 0);
    chk("ar_addr", int'(addr), 0);
    chk("ar_ok", int'(chan_ok), 0);
    repeat (2) tick();
    aclr_n = 1'b1;
    repeat (3) tick();
    chk("ar_stay_idle", int'(seq_busy), 0);
    chk("all_channels_low", nallch, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
